// File: rtl/seq_detector_core.sv
// Serial pattern detector: flags z when the last PAT_LEN bits of x equal PATTERN (overlap allowed).
// Define SEQ_DETECTOR_REG_OUT_EN for a registered, glitch-free z (one cycle later).
module seq_detector_core #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110
) (
  input  logic x,
  input  logic clk,
  input  logic reset,
  output logic z
);
  localparam int            FW       = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               match;

  generate
    if (PAT_LEN == 2) begin : g_hist_one
      always_comb hist_d = x;
    end else begin : g_hist_shift
      always_comb hist_d = {hist_q[PAT_LEN-3:0], x};
    end
  endgenerate

  // fill gates matching so bits left over from before reset never count
  always_comb begin
    fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    match  = reset && (fill_q == FILL_MAX) && ({hist_q, x} == PATTERN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQ_DETECTOR_REG_OUT_EN
  logic z_q, z_d;

  always_comb z_d = match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) z_q <= 1'b0;
    else        z_q <= z_d;
  end

  assign z = z_q;
`else
  assign z = match;
`endif

endmodule

// File: tb/tb_seq_detector_core.sv
// Table-driven bench for seq_detector_core: default 0110 instance plus a 1111 instance on the same line.
// Expected results go through a scoreboard queue; sampling point follows SEQ_DETECTOR_REG_OUT_EN.
module tb_seq_detector_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic x = 1'b0;
  logic z, z_f;

  seq_detector_core dut (.x(x), .clk(clk), .reset(reset), .z(z));
  seq_detector_core #(.PAT_LEN(4), .PATTERN(4'b1111)) dut_f (.x(x), .clk(clk), .reset(reset), .z(z_f));

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst_before;
    logic xb;
    logic ez;
    logic ezf;
  } vec_t;

  typedef struct {
    logic  ez;
    logic  ezf;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: no expected entry, want one queued");
      n_bad++;
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (z !== e.ez) begin
      $display("FAIL %s z: got %b want %b", e.tag, z, e.ez);
      n_bad++;
    end
    n_vec++;
    if (z_f !== e.ezf) begin
      $display("FAIL %s z_1111: got %b want %b", e.tag, z_f, e.ezf);
      n_bad++;
    end
  endtask

  // present one bit; comb z is judged before the consuming edge, registered z just after it
  task automatic apply(input logic xb, input logic ez, input logic ezf, input string tag);
    @(negedge clk);
    x = xb;
    sb.push_back('{ez, ezf, tag});
`ifdef SEQ_DETECTOR_REG_OUT_EN
    @(posedge clk);
    #1 check_one();
`else
    #2 check_one();
    @(posedge clk);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{1'b0, 1'b0, "reset_pulse"});
    #1 check_one();
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t vecs [0:24];

  initial begin
    // basic: 0,0,1,1,0
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    // overlap: 0,0,1,1,0,1,1,0,0,1,1,0 -> hits on 5th, 8th, 12th
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0};
    // non-match for 0110; 1111 instance fires only on the 4th bit
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // reset held while the 011 prefix is driven; nothing may be accepted
    reset = 1'b0;
    apply(1'b0, 1'b0, 1'b0, "in_reset_0");
    apply(1'b1, 1'b0, 1'b0, "in_reset_1");
    apply(1'b1, 1'b0, 1'b0, "in_reset_2");
    @(negedge clk);
    reset = 1'b1;
    // had 011 been kept, this 0 would complete the pattern
    apply(1'b0, 1'b0, 1'b0, "post_release_0");

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].rst_before) do_reset();
      apply(vecs[i].xb, vecs[i].ez, vecs[i].ezf, $sformatf("vec%0d", i));
    end

    // mid-pattern reset: 0,1,1 then short reset pulse during the next bit's low phase
    do_reset();
    apply(1'b0, 1'b0, 1'b0, "mid_0");
    apply(1'b1, 1'b0, 1'b0, "mid_1");
    apply(1'b1, 1'b0, 1'b0, "mid_2");
    @(negedge clk);
    x = 1'b0;
    reset = 1'b0;
    sb.push_back('{1'b0, 1'b0, "mid_async_clear"});
    #1 check_one();
    #2 reset = 1'b1;
    sb.push_back('{1'b0, 1'b0, "mid_after_pulse"});
`ifdef SEQ_DETECTOR_REG_OUT_EN
    @(posedge clk);
    #1 check_one();
`else
    #1 check_one();
    @(posedge clk);
`endif
    apply(1'b0, 1'b0, 1'b0, "mid_3");
    apply(1'b1, 1'b0, 1'b0, "mid_4");
    apply(1'b1, 1'b0, 1'b0, "mid_5");
    apply(1'b0, 1'b1, 1'b0, "mid_6");
    apply(1'b1, 1'b0, 1'b0, "mid_7");

    n_vec++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      n_bad++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

endmodule
